// File: rtl/coco_muldiv.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one step per cycle, plus MTHI/MTLO writes. Signed ops run on magnitudes.
module coco_muldiv #(
    parameter int N = 32
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Start,
    input  logic [2:0]   Op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cancel,
    input  logic         HiLoSel,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] Hi,
    output logic [N-1:0] Lo,
    output logic [N-1:0] Out
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_is_div, r_neg_q, r_neg_r, r_dz, r_done;
    logic [N:0]      r_acc;
    logic [N-1:0]    r_mq, r_opb, r_hi, r_lo;

    logic            w_start, w_issue, w_mthi, w_mtlo, w_last;
    logic            w_a_neg, w_b_neg;
    logic [N-1:0]    w_a_mag, w_b_mag;
    logic [N:0]      w_sum, w_sh, w_trial, w_acc_n;
    logic [N-1:0]    w_mq_n, w_q_f, w_r_f, w_hi_f, w_lo_f;
    logic [2*N-1:0]  w_prod, w_prod_f;

    // Cancel beats any same-cycle Start, including MTHI/MTLO.
    assign w_start = Start && !Cancel && (r_state == S_IDLE);
    assign w_issue = w_start && !Op[2];
    assign w_mthi  = w_start && (Op == 3'b100);
    assign w_mtlo  = w_start && (Op == 3'b101);
    assign w_last  = (r_state == S_RUN) && !Cancel && (r_cnt == CW'(1));

    assign w_a_neg = Op[0] && A[N-1];
    assign w_b_neg = Op[0] && B[N-1];
    assign w_a_mag = w_a_neg ? -A : A;
    assign w_b_mag = w_b_neg ? -B : B;

    // One iteration: {acc, mq} shifts right for multiply, left for divide.
    assign w_sum   = r_mq[0] ? (r_acc + {1'b0, r_opb}) : r_acc;
    assign w_sh    = {r_acc[N-1:0], r_mq[N-1]};
    assign w_trial = w_sh - {1'b0, r_opb};

    always_comb begin
        w_acc_n = '0;
        w_mq_n  = '0;
        if (!r_is_div) begin
            w_acc_n = {1'b0, w_sum[N:1]};
            w_mq_n  = {w_sum[0], r_mq[N-1:1]};
        end else if (!w_trial[N]) begin
            w_acc_n = w_trial;
            w_mq_n  = {r_mq[N-2:0], 1'b1};
        end else begin
            w_acc_n = w_sh;
            w_mq_n  = {r_mq[N-2:0], 1'b0};
        end
    end

    // Sign fix-up on the last step; a zero divisor leaves |A| as remainder, so Hi = A.
    assign w_prod   = {w_acc_n[N-1:0], w_mq_n};
    assign w_prod_f = r_neg_q ? -w_prod : w_prod;
    assign w_q_f    = r_dz ? '1 : (r_neg_q ? -w_mq_n : w_mq_n);
    assign w_r_f    = r_neg_r ? -w_acc_n[N-1:0] : w_acc_n[N-1:0];
    assign w_hi_f   = r_is_div ? w_r_f : w_prod_f[2*N-1:N];
    assign w_lo_f   = r_is_div ? w_q_f : w_prod_f[N-1:0];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_issue) w_next = S_RUN;
            S_RUN:  if (Cancel || r_cnt == CW'(1)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = (r_state == S_RUN);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mq     <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= w_last;
            if (w_issue) begin
                r_cnt    <= CW'(N);
                r_acc    <= '0;
                r_mq     <= w_a_mag;
                r_opb    <= w_b_mag;
                r_is_div <= Op[1];
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_dz     <= Op[1] && (B == '0);
            end else if (r_state == S_RUN) begin
                if (Cancel) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                    r_acc <= w_acc_n;
                    r_mq  <= w_mq_n;
                end
            end
            if (w_last) begin
                r_hi <= w_hi_f;
                r_lo <= w_lo_f;
            end else if (w_mthi) begin
                r_hi <= A;
            end else if (w_mtlo) begin
                r_lo <= A;
            end
        end
    end

    assign Done = r_done;
    assign Hi   = r_hi;
    assign Lo   = r_lo;
    assign Out  = HiLoSel ? r_hi : r_lo;

endmodule

// File: tb/tb_coco_muldiv.sv
// Directed bench for coco_muldiv: cycle-level arithmetic model compared every cycle,
// plus hand-computed literal expectations for each directed vector.
module tb_coco_muldiv;
    localparam int N = 32;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          Start = 1'b0;
    logic [2:0]    Op = 3'b110;
    logic [N-1:0]  A = '0;
    logic [N-1:0]  B = '0;
    logic          Cancel = 1'b0;
    logic          HiLoSel = 1'b0;
    logic          Busy, Done;
    logic [N-1:0]  Hi, Lo, Out;

    int n_checks = 0;
    int n_errors = 0;

    coco_muldiv #(.N(N)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .A(A), .B(B),
        .Cancel(Cancel), .HiLoSel(HiLoSel), .Busy(Busy), .Done(Done),
        .Hi(Hi), .Lo(Lo), .Out(Out)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural result from plain 64-bit arithmetic,
    // with a countdown of remaining busy cycles.
    logic [N-1:0] m_hi, m_lo, p_hi, p_lo;
    logic         m_done;
    int           m_left;

    task automatic compute(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                           output logic [N-1:0] hi, output logic [N-1:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000: p = {32'b0, a} * {32'b0, b};
            3'b001: p = 64'(sa * sb);
            default: p = '0;
        endcase
        hi = p[63:32];
        lo = p[31:0];
        if (op[1]) begin
            if (b == '0) begin
                lo = '1;
                hi = a;
            end else if (op[0]) begin
                q = sa / sb;
                r = sa % sb;
                lo = q[31:0];
                hi = r[31:0];
            end else begin
                lo = a / b;
                hi = a % b;
            end
        end
    endtask

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_hi = '0; m_lo = '0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (Cancel) m_left = 0;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
                    end
                end
            end else if (Start && !Cancel) begin
                if (!Op[2]) begin
                    compute(Op, A, B, p_hi, p_lo);
                    m_left = N;
                end else if (Op == 3'b100) m_hi = A;
                else if (Op == 3'b101) m_lo = A;
            end
        end
    end

    always @(negedge Clk) begin
        check("busy", 64'(Busy), 64'(m_left > 0));
        check("done", 64'(Done), 64'(m_done));
        check("hi", 64'(Hi), 64'(m_hi));
        check("lo", 64'(Lo), 64'(m_lo));
        check("out", 64'(Out), 64'(HiLoSel ? m_hi : m_lo));
    end

    task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge Clk); #1;
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk); #1;
        Start = 1'b0; Op = 3'b110; A = '0; B = '0;
    endtask

    task automatic wait_done(output int busy_cycles);
        bit seen;
        busy_cycles = 0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (Done) begin seen = 1; break; end
            if (Busy) busy_cycles++;
            @(negedge Clk); #1;
        end
        check("done_timeout", 64'(seen), 64'd1);
    endtask

    task automatic run(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        int bc;
        issue(op, a, b);
        wait_done(bc);
    endtask

    initial begin
        int bc, dones;
        repeat (3) @(negedge Clk);
        #1;
        check("rst_hi", 64'(Hi), 64'd0);
        check("rst_lo", 64'(Lo), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        Rst_n = 1'b1;

        // MULTU max*max with exact busy length
        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(bc);
        check("multu_busy_len", 64'(bc), 64'd32);
        check("multu_hi", 64'(Hi), 64'hFFFFFFFE);
        check("multu_lo", 64'(Lo), 64'h00000001);
        HiLoSel = 1'b1; #1;
        check("out_hi", 64'(Out), 64'hFFFFFFFE);
        HiLoSel = 1'b0; #1;
        check("out_lo", 64'(Out), 64'h00000001);

        run(3'b001, 32'hFFFFFFFD, 32'd5);
        check("mult_hi", 64'(Hi), 64'hFFFFFFFF);
        check("mult_lo", 64'(Lo), 64'hFFFFFFF1);
        run(3'b000, 32'hFFFFFFFD, 32'd5);
        check("multu2_hi", 64'(Hi), 64'h00000004);
        check("multu2_lo", 64'(Lo), 64'hFFFFFFF1);

        run(3'b011, 32'hFFFFFFF9, 32'd2);
        check("div_lo", 64'(Lo), 64'hFFFFFFFD);
        check("div_hi", 64'(Hi), 64'hFFFFFFFF);
        run(3'b010, 32'd100, 32'd0);
        check("divu0_lo", 64'(Lo), 64'hFFFFFFFF);
        check("divu0_hi", 64'(Hi), 64'h00000064);
        run(3'b011, 32'h80000000, 32'hFFFFFFFF);
        check("divovf_lo", 64'(Lo), 64'h80000000);
        check("divovf_hi", 64'(Hi), 64'd0);
        run(3'b011, 32'hFFFFFFF9, 32'd0);
        check("div0_neg_lo", 64'(Lo), 64'hFFFFFFFF);
        check("div0_neg_hi", 64'(Hi), 64'hFFFFFFF9);

        // MTHI then MTLO back to back
        @(negedge Clk); #1;
        Start = 1'b1; Op = 3'b100; A = 32'h12345678;
        @(negedge Clk); #1;
        check("mthi_hi", 64'(Hi), 64'h12345678);
        Op = 3'b101; A = 32'h9ABCDEF0;
        @(negedge Clk); #1;
        Start = 1'b0; Op = 3'b110; A = '0;
        check("mtlo_lo", 64'(Lo), 64'h9ABCDEF0);
        check("mt_busy", 64'(Busy), 64'd0);
        check("mt_done", 64'(Done), 64'd0);

        // MTHI while busy is ignored
        issue(3'b000, 32'd2, 32'd3);
        issue(3'b100, 32'hDEADBEEF, 32'd0);
        check("mthi_busy_hi", 64'(Hi), 64'h12345678);
        wait_done(bc);
        check("mul23_hi", 64'(Hi), 64'd0);
        check("mul23_lo", 64'(Lo), 64'd6);

        // Cancel beats a same-cycle MTHI
        @(negedge Clk); #1;
        Start = 1'b1; Op = 3'b100; A = 32'h55; Cancel = 1'b1;
        @(negedge Clk); #1;
        Start = 1'b0; Cancel = 1'b0;
        check("cancel_mthi_hi", 64'(Hi), 64'd0);

        // Cancel a DIVU in its 10th RUN cycle
        issue(3'b100, 32'h11, 32'd0);
        issue(3'b101, 32'h22, 32'd0);
        issue(3'b010, 32'd1000, 32'd3);
        repeat (9) @(negedge Clk);
        #1 Cancel = 1'b1;
        @(negedge Clk); #1;
        Cancel = 1'b0;
        check("cancel_busy", 64'(Busy), 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done) dones++;
            @(negedge Clk); #1;
        end
        check("cancel_no_done", 64'(dones), 64'd0);
        check("cancel_hi", 64'(Hi), 64'h11);
        check("cancel_lo", 64'(Lo), 64'h22);
        run(3'b010, 32'd1000, 32'd3);
        check("divu_lo", 64'(Lo), 64'd333);
        check("divu_hi", 64'(Hi), 64'd1);

        // Async reset in the middle of a MULT
        issue(3'b001, 32'd5, 32'd7);
        repeat (14) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(Busy), 64'd0);
        check("arst_done", 64'(Done), 64'd0);
        check("arst_hi", 64'(Hi), 64'd0);
        check("arst_lo", 64'(Lo), 64'd0);
        repeat (2) @(negedge Clk);
        #1 Rst_n = 1'b1;
        run(3'b000, 32'd7, 32'd6);
        check("post_rst_lo", 64'(Lo), 64'd42);
        check("post_rst_hi", 64'(Hi), 64'd0);

        repeat (2) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
